st7789_spi_monitor: RTL and testbench

ST7789_SPI_MONITOR -- requirements
Module: st7789_spi_monitor

---
 rtl/st7789_spi_monitor.sv | 165 ++++++++++++++++
 tb/tb_st7789_spi_monitor.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/st7789_spi_monitor.sv
// Passive ST7789 SPI bus monitor: decodes mode-0 serial bytes and emits them as an
// AXI-Stream, grouping consecutive same-DC bytes into packets closed by DC change or idle.
module st7789_spi_monitor #(
   parameter int IDLE_LIMIT  = 64,
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        lcd_sck,
   input  logic        lcd_sda,
   input  logic        lcd_dc,
   input  logic        lcd_rst,
   output logic [7:0]  m_axis_tdata,
   output logic        m_axis_tkeep,
   output logic        m_axis_tuser,
   output logic        m_axis_tvalid,
   output logic        m_axis_tlast,
   input  logic        m_axis_tready,
   output logic        overflow,
   output logic [31:0] byte_count
);

   localparam int IDLE_W = $clog2(IDLE_LIMIT + 1);

   typedef enum logic [1:0] {S_WAIT, S_HOLD, S_FLUSH} state_t;

   state_t state, next_state;

   logic [SYNC_STAGES-1:0] sck_sync, sda_sync, dc_sync, rst_sync;
   logic sck_s, sda_s, dc_s, rst_s, sck_prev, sck_rise, byte_done, out_free;
   logic [7:0] shift_reg, new_byte, hold_data;
   logic [2:0] bit_cnt;
   logic hold_dc;
   logic [IDLE_W-1:0] idle_cnt, idle_next;
   logic capture, load, load_last, ovf_set;

   // The synchronizers reset to zero, so the panel reset reads as asserted until
   // the real pin level has propagated; that only keeps the bit counter parked.
   always_ff @(posedge clk) begin
      if (reset) begin
         sck_sync <= '0;
         sda_sync <= '0;
         dc_sync  <= '0;
         rst_sync <= '0;
         sck_prev <= 1'b0;
      end else begin
         sck_sync <= {sck_sync[SYNC_STAGES-2:0], lcd_sck};
         sda_sync <= {sda_sync[SYNC_STAGES-2:0], lcd_sda};
         dc_sync  <= {dc_sync[SYNC_STAGES-2:0], lcd_dc};
         rst_sync <= {rst_sync[SYNC_STAGES-2:0], lcd_rst};
         sck_prev <= sck_s;
      end
   end

   assign sck_s     = sck_sync[SYNC_STAGES-1];
   assign sda_s     = sda_sync[SYNC_STAGES-1];
   assign dc_s      = dc_sync[SYNC_STAGES-1];
   assign rst_s     = rst_sync[SYNC_STAGES-1];
   assign sck_rise  = sck_s & ~sck_prev;
   assign new_byte  = {shift_reg[6:0], sda_s};
   assign byte_done = sck_rise & rst_s & (bit_cnt == 3'd7);
   assign out_free  = ~m_axis_tvalid | m_axis_tready;

   always_ff @(posedge clk) begin
      if (reset || !rst_s) begin
         shift_reg <= '0;
         bit_cnt   <= '0;
      end else if (sck_rise) begin
         shift_reg <= new_byte;
         bit_cnt   <= bit_cnt + 3'd1;
      end
   end

   always_comb begin
      next_state = state;
      idle_next  = idle_cnt;
      capture    = 1'b0;
      load       = 1'b0;
      load_last  = 1'b0;
      ovf_set    = 1'b0;
      case (state)
         S_WAIT: begin
            idle_next = '0;
            if (byte_done) begin
               capture    = 1'b1;
               next_state = S_HOLD;
            end
         end
         S_HOLD: begin
            if (byte_done) begin
               idle_next = '0;
               if (out_free) begin
                  load      = 1'b1;
                  load_last = (dc_s != hold_dc);
                  capture   = 1'b1;
               end else begin
                  ovf_set = 1'b1;
               end
            end else if (!rst_s) begin
               idle_next  = '0;
               next_state = S_FLUSH;
            end else if (sck_rise) begin
               idle_next = '0;
            end else if (idle_cnt == IDLE_W'(IDLE_LIMIT - 1)) begin
               idle_next  = '0;
               next_state = S_FLUSH;
            end else begin
               idle_next = idle_cnt + 1'b1;
            end
         end
         S_FLUSH: begin
            idle_next = '0;
            if (out_free) begin
               load       = 1'b1;
               load_last  = 1'b1;
               next_state = S_WAIT;
               // A byte finishing as the flush leaves opens the next packet.
               if (byte_done) begin
                  capture    = 1'b1;
                  next_state = S_HOLD;
               end
            end else if (byte_done) begin
               ovf_set = 1'b1;
            end
         end
         default: next_state = S_WAIT;
      endcase
   end

   // Output loads always take the previously held byte, so capture and load may coincide.
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= S_WAIT;
         idle_cnt      <= '0;
         hold_data     <= '0;
         hold_dc       <= 1'b0;
         m_axis_tdata  <= '0;
         m_axis_tuser  <= 1'b0;
         m_axis_tlast  <= 1'b0;
         m_axis_tvalid <= 1'b0;
         overflow      <= 1'b0;
         byte_count    <= '0;
      end else begin
         state    <= next_state;
         idle_cnt <= idle_next;
         if (capture) begin
            hold_data  <= new_byte;
            hold_dc    <= dc_s;
            byte_count <= byte_count + 32'd1;
         end
         if (ovf_set) overflow <= 1'b1;
         if (load) begin
            m_axis_tdata  <= hold_data;
            m_axis_tuser  <= hold_dc;
            m_axis_tlast  <= load_last;
            m_axis_tvalid <= 1'b1;
         end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
         end
      end
   end

   assign m_axis_tkeep = m_axis_tvalid;

endmodule

// File: tb/tb_st7789_spi_monitor.sv
// Directed bench for st7789_spi_monitor: drives SPI bytes, records accepted AXI beats
// and compares them with hand-computed packets.
module tb_st7789_spi_monitor;

   logic        clk = 1'b0;
   logic        reset;
   logic        lcd_sck, lcd_sda, lcd_dc, lcd_rst;
   logic [7:0]  m_axis_tdata;
   logic        m_axis_tkeep, m_axis_tuser, m_axis_tvalid, m_axis_tlast, m_axis_tready;
   logic        overflow;
   logic [31:0] byte_count;

   int n_checks = 0;
   int n_fail   = 0;
   int rd_idx   = 0;
   logic [10:0] beats[$];

   st7789_spi_monitor #(.IDLE_LIMIT(64), .SYNC_STAGES(2)) dut (
      .clk(clk), .reset(reset),
      .lcd_sck(lcd_sck), .lcd_sda(lcd_sda), .lcd_dc(lcd_dc), .lcd_rst(lcd_rst),
      .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tuser(m_axis_tuser),
      .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
      .overflow(overflow), .byte_count(byte_count)
   );

   always #5 clk = ~clk;

   // Inputs change at posedge+2, so a handshake seen at negedge completes at the next posedge.
   always @(negedge clk) begin
      if (m_axis_tvalid && m_axis_tready)
         beats.push_back({m_axis_tkeep, m_axis_tuser, m_axis_tlast, m_axis_tdata});
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_checks++;
      if (observed !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Sends the top nbits of data MSB first; SCK period is six clocks.
   task automatic applyStimulus(input logic [7:0] data, input logic dc, input int nbits);
      for (int i = 7; i > 7 - nbits; i--) begin
         lcd_sda = data[i];
         lcd_dc  = dc;
         tick(3);
         lcd_sck = 1'b1;
         tick(3);
         lcd_sck = 1'b0;
      end
   endtask

   task automatic checkBeat(input string tag, input logic [7:0] d, input logic u, input logic l);
      logic [10:0] b;
      checkOutput({tag, "_present"}, 32'(beats.size() > rd_idx), 32'd1);
      if (beats.size() > rd_idx) begin
         b = beats[rd_idx];
         rd_idx++;
         checkOutput({tag, "_tdata"}, 32'(b[7:0]), 32'(d));
         checkOutput({tag, "_tlast"}, 32'(b[8]), 32'(l));
         checkOutput({tag, "_tuser"}, 32'(b[9]), 32'(u));
         checkOutput({tag, "_tkeep"}, 32'(b[10]), 32'd1);
      end
   endtask

   initial begin
      reset = 1'b1;
      lcd_sck = 1'b0; lcd_sda = 1'b0; lcd_dc = 1'b0; lcd_rst = 1'b1;
      m_axis_tready = 1'b1;
      tick(5);
      reset = 1'b0;
      tick(1);
      checkOutput("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
      checkOutput("rst_tkeep", 32'(m_axis_tkeep), 32'd0);
      checkOutput("rst_tdata", 32'(m_axis_tdata), 32'd0);
      checkOutput("rst_overflow", 32'(overflow), 32'd0);
      checkOutput("rst_count", byte_count, 32'd0);
      tick(5);

      // Single command byte closed by idle timeout
      applyStimulus(8'h2C, 1'b0, 8);
      tick(100);
      checkBeat("cmd2c", 8'h2C, 1'b0, 1'b1);
      checkOutput("cmd2c_count", byte_count, 32'd1);
      checkOutput("cmd2c_nbeats", 32'(beats.size()), 32'd1);

      // Command followed by a data packet; DC change closes the command
      applyStimulus(8'h2A, 1'b0, 8);
      applyStimulus(8'h00, 1'b1, 8);
      applyStimulus(8'h00, 1'b1, 8);
      applyStimulus(8'h00, 1'b1, 8);
      applyStimulus(8'hEF, 1'b1, 8);
      tick(100);
      checkBeat("caset_cmd", 8'h2A, 1'b0, 1'b1);
      checkBeat("caset_d0", 8'h00, 1'b1, 1'b0);
      checkBeat("caset_d1", 8'h00, 1'b1, 1'b0);
      checkBeat("caset_d2", 8'h00, 1'b1, 1'b0);
      checkBeat("caset_d3", 8'hEF, 1'b1, 1'b1);
      checkOutput("caset_count", byte_count, 32'd6);
      checkOutput("caset_nbeats", 32'(beats.size()), 32'd6);

      // Backpressure: third byte dropped, first byte held stable
      m_axis_tready = 1'b0;
      applyStimulus(8'hA1, 1'b1, 8);
      applyStimulus(8'hA2, 1'b1, 8);
      applyStimulus(8'hA3, 1'b1, 8);
      tick(4);
      checkOutput("bp_tvalid", 32'(m_axis_tvalid), 32'd1);
      checkOutput("bp_tdata", 32'(m_axis_tdata), 32'hA1);
      checkOutput("bp_tlast", 32'(m_axis_tlast), 32'd0);
      checkOutput("bp_overflow", 32'(overflow), 32'd1);
      checkOutput("bp_count", byte_count, 32'd8);
      tick(80);
      checkOutput("bp_stable_tvalid", 32'(m_axis_tvalid), 32'd1);
      checkOutput("bp_stable_tdata", 32'(m_axis_tdata), 32'hA1);
      checkOutput("bp_stable_tuser", 32'(m_axis_tuser), 32'd1);
      m_axis_tready = 1'b1;
      tick(100);
      checkBeat("bp_a1", 8'hA1, 1'b1, 1'b0);
      checkBeat("bp_a2", 8'hA2, 1'b1, 1'b1);
      checkOutput("bp_nbeats", 32'(beats.size()), 32'd8);

      // Panel reset mid-byte flushes the held byte and discards the partial bits
      applyStimulus(8'h3A, 1'b0, 8);
      applyStimulus(8'hFF, 1'b0, 5);
      lcd_rst = 1'b0;
      tick(10);
      lcd_rst = 1'b1;
      tick(10);
      applyStimulus(8'h11, 1'b0, 8);
      tick(100);
      checkBeat("lcdrst_held", 8'h3A, 1'b0, 1'b1);
      checkBeat("lcdrst_11", 8'h11, 1'b0, 1'b1);
      checkOutput("lcdrst_count", byte_count, 32'd10);
      checkOutput("lcdrst_nbeats", 32'(beats.size()), 32'd10);
      checkOutput("lcdrst_overflow_sticky", 32'(overflow), 32'd1);

      // Module reset with an output beat pending and a byte held
      m_axis_tready = 1'b0;
      applyStimulus(8'h55, 1'b1, 8);
      applyStimulus(8'h66, 1'b1, 8);
      tick(4);
      checkOutput("mrst_pre_tvalid", 32'(m_axis_tvalid), 32'd1);
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      checkOutput("mrst_tvalid", 32'(m_axis_tvalid), 32'd0);
      checkOutput("mrst_overflow", 32'(overflow), 32'd0);
      checkOutput("mrst_count", byte_count, 32'd0);
      m_axis_tready = 1'b1;
      tick(5);
      applyStimulus(8'h36, 1'b0, 8);
      tick(100);
      checkBeat("mrst_36", 8'h36, 1'b0, 1'b1);
      checkOutput("mrst_36_count", byte_count, 32'd1);
      checkOutput("mrst_nbeats", 32'(beats.size()), 32'd11);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
